// File: rtl/pmips_ctrl_pkg.sv
// Shared types and encodings for the PMIPS multi-cycle main controller.
package pmips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_BR_RES  = 3'd5,
        S_BR_WAIT = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_NOP     = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_e;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_RSVD  = 3'd1;
    localparam logic [2:0] OP_BEQ   = 3'd2;
    localparam logic [2:0] OP_ADDI  = 3'd3;
    localparam logic [2:0] OP_LW    = 3'd4;
    localparam logic [2:0] OP_SW    = 3'd5;
    localparam logic [2:0] OP_J     = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pmips_op_decode.sv
// Combinational opcode classifier: maps an opcode to its instruction class
// and flags encodings that are reserved or lie at/above 8.
module pmips_op_decode
    import pmips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 3
) (
    input  logic [OP_WIDTH-1:0] op,
    output op_class_e           op_class,
    output logic                legal
);

    logic [31:0] op_ext;

    // Zero-extend first so wide opcodes outside the defined range fall to illegal.
    always_comb begin
        op_ext   = 32'(op);
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
        if (op_ext < 32'd8) begin
            case (op_ext[2:0])
                OP_RTYPE: begin op_class = CLS_RTYPE; legal = 1'b1; end
                OP_BEQ:   begin op_class = CLS_BEQ;   legal = 1'b1; end
                OP_ADDI:  begin op_class = CLS_ADDI;  legal = 1'b1; end
                OP_LW:    begin op_class = CLS_LW;    legal = 1'b1; end
                OP_SW:    begin op_class = CLS_SW;    legal = 1'b1; end
                OP_J:     begin op_class = CLS_J;     legal = 1'b1; end
                OP_NOP:   begin op_class = CLS_NOP;   legal = 1'b1; end
                OP_RSVD:  begin op_class = CLS_ILLEGAL; legal = 1'b0; end
                default:  begin op_class = CLS_ILLEGAL; legal = 1'b0; end
            endcase
        end else begin
            op_class = CLS_ILLEGAL;
            legal    = 1'b0;
        end
    end

endmodule

// File: rtl/pmips_control_fsm.sv
// PMIPS multi-cycle main controller. Outputs are registered from the next
// state, so each output register always matches the state register.
module pmips_control_fsm
    import pmips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 3,
    parameter int ALUOP_WIDTH = 2,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    opcode,
    input  logic                   opcode_valid,
    input  logic                   mem_ready,
    input  logic                   zero,
    output logic                   PCStall,
    output logic                   PCSrc,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic                   ALUSrc,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   Branch,
    output logic                   MemWrite,
    output logic                   MemRead,
    output logic                   MemtoReg,
    output logic                   busy,
    output logic                   illegal_op,
    output logic                   mem_timeout
);

    localparam int CNT_W = $clog2(max_int(MEM_TIMEOUT, BR_PENALTY) + 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BR_LAST  = CNT_W'(BR_PENALTY - 1);

    state_e              state_r, state_nxt;
    logic [OP_WIDTH-1:0] op_r, op_nxt;
    logic                taken_r, taken_nxt;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt;
    logic                timeout_nxt;
    op_class_e           op_class_s;
    logic                legal_s;

    logic                   pcstall_nxt, pcsrc_nxt, regwrite_nxt, regdst_nxt;
    logic                   alusrc_nxt, branch_nxt, memwrite_nxt, memread_nxt;
    logic                   memtoreg_nxt, busy_nxt, illegal_nxt;
    logic [ALUOP_WIDTH-1:0] aluop_nxt;

    // op_nxt equals the latch outside IDLE, so one decoder serves every state.
    pmips_op_decode #(.OP_WIDTH(OP_WIDTH)) u_decode (
        .op       (op_nxt),
        .op_class (op_class_s),
        .legal    (legal_s)
    );

    // Next-state, latch and counter logic.
    always_comb begin
        state_nxt   = state_r;
        op_nxt      = op_r;
        taken_nxt   = taken_r;
        cnt_nxt     = cnt_r;
        timeout_nxt = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (opcode_valid) begin
                    op_nxt    = opcode;
                    taken_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_DECODE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DECODE: begin
                if (legal_s) state_nxt = S_EXEC;
                else         state_nxt = S_IDLE;
            end
            S_EXEC: begin
                cnt_nxt = '0;
                case (op_class_s)
                    CLS_RTYPE, CLS_ADDI: state_nxt = S_WB;
                    CLS_LW, CLS_SW:      state_nxt = S_MEM;
                    CLS_BEQ: begin taken_nxt = zero; state_nxt = S_BR_RES; end
                    CLS_J:   begin taken_nxt = 1'b1; state_nxt = S_BR_RES; end
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_class_s == CLS_LW) state_nxt = S_WB;
                    else                      state_nxt = S_IDLE;
                end else if (cnt_r == MEM_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            S_WB: state_nxt = S_IDLE;
            S_BR_RES: begin
                cnt_nxt = '0;
                if (BR_PENALTY > 0) state_nxt = S_BR_WAIT;
                else                state_nxt = S_IDLE;
            end
            S_BR_WAIT: begin
                if (cnt_r == BR_LAST) state_nxt = S_IDLE;
                else                  cnt_nxt = cnt_r + CNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode of the upcoming state, registered below.
    always_comb begin
        pcstall_nxt  = (state_nxt != S_IDLE);
        busy_nxt     = (state_nxt != S_IDLE);
        pcsrc_nxt    = 1'b0;
        regwrite_nxt = 1'b0;
        regdst_nxt   = 1'b0;
        alusrc_nxt   = 1'b0;
        aluop_nxt    = ALUOP_WIDTH'(ALU_ADD);
        branch_nxt   = 1'b0;
        memwrite_nxt = 1'b0;
        memread_nxt  = 1'b0;
        memtoreg_nxt = 1'b0;
        illegal_nxt  = 1'b0;
        case (state_nxt)
            S_DECODE: illegal_nxt = ~legal_s;
            S_EXEC: begin
                case (op_class_s)
                    CLS_RTYPE: begin regdst_nxt = 1'b1; aluop_nxt = ALUOP_WIDTH'(ALU_FUNCT); end
                    CLS_ADDI, CLS_LW, CLS_SW: alusrc_nxt = 1'b1;
                    CLS_BEQ:   begin branch_nxt = 1'b1; aluop_nxt = ALUOP_WIDTH'(ALU_SUB); end
                    default:   aluop_nxt = ALUOP_WIDTH'(ALU_ADD);
                endcase
            end
            S_MEM: begin
                alusrc_nxt   = 1'b1;
                memread_nxt  = (op_class_s == CLS_LW);
                memwrite_nxt = (op_class_s == CLS_SW);
            end
            S_WB: begin
                regwrite_nxt = 1'b1;
                regdst_nxt   = (op_class_s == CLS_RTYPE);
                memtoreg_nxt = (op_class_s == CLS_LW);
            end
            S_BR_RES: pcsrc_nxt = taken_nxt;
            default:  pcsrc_nxt = 1'b0;
        endcase
    end

    // State, latches and registered outputs; reset aborts any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            op_r        <= '0;
            taken_r     <= 1'b0;
            cnt_r       <= '0;
            PCStall     <= 1'b0;
            PCSrc       <= 1'b0;
            RegWrite    <= 1'b0;
            RegDst      <= 1'b0;
            ALUSrc      <= 1'b0;
            ALUOp       <= '0;
            Branch      <= 1'b0;
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            MemtoReg    <= 1'b0;
            busy        <= 1'b0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            op_r        <= op_nxt;
            taken_r     <= taken_nxt;
            cnt_r       <= cnt_nxt;
            PCStall     <= pcstall_nxt;
            PCSrc       <= pcsrc_nxt;
            RegWrite    <= regwrite_nxt;
            RegDst      <= regdst_nxt;
            ALUSrc      <= alusrc_nxt;
            ALUOp       <= aluop_nxt;
            Branch      <= branch_nxt;
            MemWrite    <= memwrite_nxt;
            MemRead     <= memread_nxt;
            MemtoReg    <= memtoreg_nxt;
            busy        <= busy_nxt;
            illegal_op  <= illegal_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_pmips_control_fsm.sv
// Directed bench for pmips_control_fsm: a default instance and a second one
// with a 4-bit opcode and no branch penalty.
module tb_pmips_control_fsm;

    logic       clock;
    logic       reset;
    logic [3:0] opcode;
    logic       opcode_valid;
    logic       mem_ready;
    logic       zero;
    logic       sel;

    logic       a_PCStall, a_PCSrc, a_RegWrite, a_RegDst, a_ALUSrc, a_Branch;
    logic       a_MemWrite, a_MemRead, a_MemtoReg, a_busy, a_illegal, a_timeout;
    logic [1:0] a_ALUOp;
    logic       b_PCStall, b_PCSrc, b_RegWrite, b_RegDst, b_ALUSrc, b_Branch;
    logic       b_MemWrite, b_MemRead, b_MemtoReg, b_busy, b_illegal, b_timeout;
    logic [1:0] b_ALUOp;

    logic [13:0] a_out, b_out, o;

    int n_checks = 0;
    int n_fail   = 0;
    int lat, n_stall, n_rd, n_wr, n_rw, n_pcsrc, n_branch, n_ill, n_to;
    logic       regdst_e, alusrc_e, branch_e, regdst_w, memtoreg_w;
    logic [1:0] aluop_e;

    pmips_control_fsm u_dut_a (
        .clock(clock), .reset(reset), .opcode(opcode[2:0]),
        .opcode_valid(opcode_valid & ~sel), .mem_ready(mem_ready), .zero(zero),
        .PCStall(a_PCStall), .PCSrc(a_PCSrc), .RegWrite(a_RegWrite), .RegDst(a_RegDst),
        .ALUSrc(a_ALUSrc), .ALUOp(a_ALUOp), .Branch(a_Branch), .MemWrite(a_MemWrite),
        .MemRead(a_MemRead), .MemtoReg(a_MemtoReg), .busy(a_busy),
        .illegal_op(a_illegal), .mem_timeout(a_timeout)
    );

    pmips_control_fsm #(.OP_WIDTH(4), .BR_PENALTY(0)) u_dut_b (
        .clock(clock), .reset(reset), .opcode(opcode),
        .opcode_valid(opcode_valid & sel), .mem_ready(mem_ready), .zero(zero),
        .PCStall(b_PCStall), .PCSrc(b_PCSrc), .RegWrite(b_RegWrite), .RegDst(b_RegDst),
        .ALUSrc(b_ALUSrc), .ALUOp(b_ALUOp), .Branch(b_Branch), .MemWrite(b_MemWrite),
        .MemRead(b_MemRead), .MemtoReg(b_MemtoReg), .busy(b_busy),
        .illegal_op(b_illegal), .mem_timeout(b_timeout)
    );

    // Bit map: 13 PCStall 12 PCSrc 11 RegWrite 10 RegDst 9 ALUSrc 8:7 ALUOp
    // 6 Branch 5 MemWrite 4 MemRead 3 MemtoReg 2 busy 1 illegal_op 0 mem_timeout
    assign a_out = {a_PCStall, a_PCSrc, a_RegWrite, a_RegDst, a_ALUSrc, a_ALUOp, a_Branch,
                    a_MemWrite, a_MemRead, a_MemtoReg, a_busy, a_illegal, a_timeout};
    assign b_out = {b_PCStall, b_PCSrc, b_RegWrite, b_RegDst, b_ALUSrc, b_ALUOp, b_Branch,
                    b_MemWrite, b_MemRead, b_MemtoReg, b_busy, b_illegal, b_timeout};
    assign o = sel ? b_out : a_out;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one instruction and tally outputs until the first idle cycle.
    task automatic run(input logic s, input logic [3:0] op, input logic z, input int rdy_at);
        int  mc;
        bit  done;
        sel = s; opcode = op; zero = z; mem_ready = 1'b0; opcode_valid = 1'b1;
        lat = 0; n_stall = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_pcsrc = 0;
        n_branch = 0; n_ill = 0; n_to = 0; mc = 0; done = 1'b0;
        regdst_e = 1'b0; alusrc_e = 1'b0; branch_e = 1'b0; aluop_e = 2'd0;
        regdst_w = 1'b0; memtoreg_w = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clock); #1;
            opcode_valid = 1'b0;
            opcode = ~op;
            if (o[2]) lat++; else done = 1'b1;
            n_stall  += int'(o[13]);
            n_pcsrc  += int'(o[12]);
            n_rw     += int'(o[11]);
            n_branch += int'(o[6]);
            n_wr     += int'(o[5]);
            n_rd     += int'(o[4]);
            n_ill    += int'(o[1]);
            n_to     += int'(o[0]);
            if (c == 2) begin
                regdst_e = o[10]; alusrc_e = o[9]; aluop_e = o[8:7]; branch_e = o[6];
            end
            if (o[11]) begin
                regdst_w = o[10]; memtoreg_w = o[3];
            end
            if (o[5] | o[4]) mc++;
            mem_ready = (o[5] | o[4]) && (mc == rdy_at);
        end
        mem_ready = 1'b0;
        check("run_bound", 32'(done), 32'd1);
    endtask

    initial begin
        int rw_after;
        reset = 1'b0; sel = 1'b0; opcode = 4'd3; opcode_valid = 1'b1;
        mem_ready = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_a_out", 32'(a_out), 32'd0);
        check("reset_b_out", 32'(b_out), 32'd0);
        reset = 1'b1;

        run(1'b0, 4'd3, 1'b0, 0);
        check("addi_lat", 32'(lat), 32'd3);
        check("addi_alusrc", 32'(alusrc_e), 32'd1);
        check("addi_aluop", 32'(aluop_e), 32'd0);
        check("addi_rw", 32'(n_rw), 32'd1);
        check("addi_regdst_wb", 32'(regdst_w), 32'd0);

        run(1'b0, 4'd0, 1'b0, 0);
        check("r_regdst_ex", 32'(regdst_e), 32'd1);
        check("r_aluop", 32'(aluop_e), 32'd2);
        check("r_rw", 32'(n_rw), 32'd1);
        check("r_regdst_wb", 32'(regdst_w), 32'd1);
        check("r_memtoreg_wb", 32'(memtoreg_w), 32'd0);
        check("r_stall", 32'(n_stall), 32'd3);

        run(1'b0, 4'd2, 1'b1, 0);
        check("beq_t_branch", 32'(branch_e), 32'd1);
        check("beq_t_aluop", 32'(aluop_e), 32'd1);
        check("beq_t_pcsrc", 32'(n_pcsrc), 32'd1);
        check("beq_t_lat", 32'(lat), 32'd5);
        check("beq_t_rw", 32'(n_rw), 32'd0);
        run(1'b0, 4'd2, 1'b0, 0);
        check("beq_nt_pcsrc", 32'(n_pcsrc), 32'd0);
        check("beq_nt_lat", 32'(lat), 32'd5);
        run(1'b0, 4'd6, 1'b0, 0);
        check("j_pcsrc", 32'(n_pcsrc), 32'd1);
        check("j_branch", 32'(n_branch), 32'd0);
        check("j_lat", 32'(lat), 32'd5);

        run(1'b0, 4'd4, 1'b0, 4);
        check("lw_rd", 32'(n_rd), 32'd4);
        check("lw_rw", 32'(n_rw), 32'd1);
        check("lw_memtoreg", 32'(memtoreg_w), 32'd1);
        check("lw_lat", 32'(lat), 32'd7);
        check("lw_to", 32'(n_to), 32'd0);

        run(1'b0, 4'd5, 1'b0, 0);
        check("sw_to_wr", 32'(n_wr), 32'd15);
        check("sw_to_pulse", 32'(n_to), 32'd1);
        check("sw_to_rw", 32'(n_rw), 32'd0);
        check("sw_to_lat", 32'(lat), 32'd17);
        run(1'b0, 4'd5, 1'b0, 15);
        check("sw_last_wr", 32'(n_wr), 32'd15);
        check("sw_last_to", 32'(n_to), 32'd0);
        run(1'b0, 4'd5, 1'b0, 1);
        check("sw_fast_lat", 32'(lat), 32'd3);
        check("sw_fast_wr", 32'(n_wr), 32'd1);

        run(1'b0, 4'd1, 1'b0, 0);
        check("rsvd_ill", 32'(n_ill), 32'd1);
        check("rsvd_lat", 32'(lat), 32'd1);
        check("rsvd_writes", 32'(n_rw + n_wr), 32'd0);
        run(1'b0, 4'd7, 1'b0, 0);
        check("nop_lat", 32'(lat), 32'd2);
        check("nop_ill", 32'(n_ill), 32'd0);

        run(1'b1, 4'd9, 1'b0, 0);
        check("w4_op9_ill", 32'(n_ill), 32'd1);
        check("w4_op9_lat", 32'(lat), 32'd1);
        check("w4_op9_writes", 32'(n_rw + n_wr), 32'd0);
        run(1'b1, 4'd2, 1'b1, 0);
        check("p0_beq_lat", 32'(lat), 32'd3);
        check("p0_beq_pcsrc", 32'(n_pcsrc), 32'd1);

        sel = 1'b0; opcode = 4'd4; opcode_valid = 1'b1;
        @(posedge clock); #1;
        opcode_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_pre_memread", 32'(a_MemRead), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_memread", 32'(a_MemRead), 32'd0);
        check("rst_async_busy", 32'(a_busy), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        rw_after = 0;
        repeat (6) begin
            @(posedge clock); #1;
            rw_after += int'(a_RegWrite) + int'(a_busy);
        end
        check("rst_no_wb", 32'(rw_after), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pmips_control_fsm.md
Name: pmips_control_fsm

Overview:
- Parametrised multi-cycle main controller for the PMIPS core. It replaces the fixed 3-bit single-state Control block.
- It accepts the opcode from the IF/ID register, sequences each instruction through decode, execute, memory and writeback states, and drives the datapath control lines.
- New over the previous controller:
  - configurable opcode/ALUOp width
  - memory-ready handshake with timeout
  - configurable branch penalty
  - illegal-opcode detection

Parameters:
- OP_WIDTH, 3, opcode width. Encodings at or above 8 are illegal.
- ALUOP_WIDTH, 2, ALUOp bus width. Must be at least 2.
- BR_PENALTY, 2, stall cycles after branch resolution (0..15). 0 means no wait state.
- MEM_TIMEOUT, 15, maximum MEM cycles waiting for mem_ready (1..255).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  OP_WIDTH  opcode from IF/ID register
- opcode_valid  in  1  opcode is a new instruction. Sampled only in IDLE.
- mem_ready  in  1  data memory completed access this cycle
- zero  in  1  ALU zero flag, sampled in EXEC for BEQ
- PCStall  out  1  hold PC
- PCSrc  out  1  select branch target
- RegWrite  out  1  register file write enable
- RegDst  out  1  1 selects rd, 0 selects rt
- ALUSrc  out  1  1 selects immediate
- ALUOp  out  ALUOP_WIDTH  ALU operation class
- Branch  out  1  branch instruction in EXEC
- MemWrite  out  1  data memory write
- MemRead  out  1  data memory read
- MemtoReg  out  1  writeback from memory
- busy  out  1  state is not IDLE
- illegal_op  out  1  one-cycle pulse on undefined opcode
- mem_timeout  out  1  one-cycle pulse on memory timeout

Behaviour:
- Moore machine. All outputs decode from the state register, the latched opcode and the latched branch_taken bit. No combinational path from inputs to outputs.
- Reset (asserted low, asynchronous):
  - state = IDLE; opcode latch, counters and branch_taken = 0; every output = 0.
  - Reset mid-instruction aborts it immediately. No further RegWrite or MemWrite is issued.
- States: IDLE, DECODE, EXEC, MEM, WB, BR_RES, BR_WAIT.
- IDLE:
  - All outputs 0.
  - If opcode_valid = 1, latch opcode and go to DECODE.
- DECODE:
  - PCStall = 1.
  - Illegal opcode: illegal_op = 1 this cycle, then back to IDLE with no writes.
  - Otherwise go to EXEC.
- PCStall = 1 in every state except IDLE.
- EXEC, per opcode class (ALUOp: 0 = add, 1 = sub, 2 = funct):
  - R-type (0): RegDst = 1, ALUOp = 2, then WB.
  - ADDI (3): ALUSrc = 1, ALUOp = 0, then WB.
  - LW (4) and SW (5): ALUSrc = 1, ALUOp = 0, then MEM.
  - BEQ (2): Branch = 1, ALUOp = 1. Latch branch_taken = zero, then BR_RES.
  - J (6): go to BR_RES with branch_taken forced to 1.
  - NOP (7): return to IDLE.
  - Encoding 1 is reserved and flagged illegal in DECODE.
- MEM:
  - LW asserts MemRead = 1 and ALUSrc = 1. SW asserts MemWrite = 1 and ALUSrc = 1.
  - The wait counter starts at 0 on entry and increments each cycle.
  - mem_ready = 1 in the same cycle: LW goes to WB, SW goes to IDLE.
  - Counter reaches MEM_TIMEOUT-1 without mem_ready: pulse mem_timeout, return to IDLE. No WB occurs.
  - mem_ready arriving in the final allowed cycle counts as success.
- WB:
  - RegWrite = 1.
  - R-type: RegDst = 1. LW: MemtoReg = 1. ADDI: RegDst = 0.
  - Then IDLE.
- BR_RES:
  - PCSrc = branch_taken for exactly this cycle.
  - Go to BR_WAIT if BR_PENALTY > 0, else IDLE.
- BR_WAIT:
  - Hold for BR_PENALTY cycles with a counter, then IDLE.
- Latency (cycles from opcode_valid sampled to return to IDLE):

  | Instruction | Latency |
  |---|---|
  | R-type, ADDI | 3 |
  | SW | 3 + wait |
  | LW | 4 + wait |
  | BEQ, J | 3 + BR_PENALTY |
  | NOP | 2 |
  | Illegal | 1 |

- opcode_valid and opcode changes outside IDLE are ignored.
- Width rules:
  - ALUOp values are zero-extended to ALUOP_WIDTH.
  - Counter widths are sized to hold MEM_TIMEOUT and BR_PENALTY.

Decomposition:
- Package pmips_ctrl_pkg holds:
  - state enum
  - opcode constants: OP_RTYPE = 0, OP_RSVD = 1, OP_BEQ = 2, OP_ADDI = 3, OP_LW = 4, OP_SW = 5, OP_J = 6, OP_NOP = 7
  - ALUOp constants: ALU_ADD = 0, ALU_SUB = 1, ALU_FUNCT = 2
- One sub-module: pmips_op_decode. It is combinational and maps the latched opcode to a class and a legal flag. The FSM and output decode stay in the top.

Test Plan:
- Reset low for 2 cycles with opcode = 3 and opcode_valid = 1. Required: all outputs 0, busy = 0. After release, the ADDI sequence sets ALUSrc = 1 in EXEC and RegWrite = 1 in WB, and busy drops 3 cycles after the opcode_valid sample.
- R-type, opcode = 0. Required: EXEC has RegDst = 1, ALUOp = 2. WB has RegWrite = 1, RegDst = 1, MemtoReg = 0. PCStall = 1 for exactly 3 cycles.
- BEQ, opcode = 2, zero = 1, BR_PENALTY = 2. Required: Branch = 1 and ALUOp = 1 in EXEC, PCSrc = 1 for one cycle, then 2 BR_WAIT cycles. Repeating with zero = 0 gives PCSrc = 0 throughout.
- LW, opcode = 4, mem_ready after 3 wait cycles. Required: MemRead = 1 for 4 cycles, then WB with RegWrite = 1 and MemtoReg = 1. SW, opcode = 5, with mem_ready never asserted and MEM_TIMEOUT = 15: MemWrite held 15 cycles, mem_timeout pulses once, no RegWrite.
- Opcode = 1. Required: illegal_op = 1 for one cycle in DECODE, then IDLE with no writes. With OP_WIDTH = 4, opcode = 9 behaves the same.
- Reset asserted during LW MEM. Required: MemRead = 0 immediately (asynchronously), state IDLE, no WB cycle.
